// File: rtl/fp_pkg.sv
// Shared types and constants for the FP16 write-back path: the queued result
// entry, its destination kind, and the bit positions of the sticky flags.
package fp_pkg;

   typedef enum logic {
      VECTOR = 1'b0,
      SCALAR = 1'b1
   } fp_wb_kind_e;

   typedef struct packed {
      fp_wb_kind_e kind;
      logic [4:0]  rd;
      logic [15:0] data16;
      logic [31:0] data32;
   } fp_wb_entry_t;

   localparam int FFLAG_OF   = 0;
   localparam int FFLAG_NV   = 1;
   localparam int FFLAG_DROP = 2;

   localparam int FP_WB_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/fp_wb_fifo.sv
// Circular result queue for the write-back buffer. The caller decides when a
// push or pop is accepted; this block only stores entries and tracks occupancy.
module fp_wb_fifo
   import fp_pkg::*;
#(
   parameter int  DEPTH   = FP_WB_DEFAULT_DEPTH,
   parameter type entry_t = fp_wb_entry_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  entry_t                     pushData,
   input  logic                       pop,
   output entry_t                     headData,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   entry_t        mem [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two. Occupancy is
   // kept as an explicit counter so full and empty never alias when the
   // pointers are equal.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage needs no reset: entries are only ever visible through the head
   // while count says they are live, and reset clears count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr] <= pushData;
      end
   end

   // The head is a plain read of the oldest slot, so a write made this cycle
   // cannot reach the outputs before the next cycle.
   always_comb begin
      headData = mem[rdPtr];
      empty    = (count == '0);
      full     = (count == CW'(DEPTH));
   end

endmodule

// File: rtl/fp_wb_buffer.sv
// Write-back buffer between the 1-cycle FP16 ALU and the vector/scalar
// register files: queues results in order, routes each to one RF, keeps flags.
module fp_wb_buffer
   import fp_pkg::*;
#(
   parameter int DEPTH = FP_WB_DEFAULT_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [4:0]             in_rd,
   input  logic [15:0]            in_data,
   input  logic                   in_scalar_valid,
   input  logic [31:0]            in_scalar_data,
   input  logic                   in_err_overflow,
   input  logic                   in_err_invalid,
   output logic                   issue_ready,
   output logic                   vrf_wr_valid,
   output logic [4:0]             vrf_wr_rd,
   output logic [15:0]            vrf_wr_data,
   input  logic                   vrf_wr_ready,
   output logic                   srf_wr_valid,
   output logic [4:0]             srf_wr_rd,
   output logic [31:0]            srf_wr_data,
   input  logic                   srf_wr_ready,
   input  logic                   flags_clr,
   output logic [2:0]             fflags,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] ISSUE_LIMIT = (CW + 1)'(DEPTH - 1);

   fp_wb_entry_t newEntry;
   fp_wb_entry_t headEntry;
   logic         fifoEmpty;
   logic         fifoFull;
   logic [CW-1:0] fifoCount;
   logic         pushOk;
   logic         popOk;
   logic [2:0]   flagSet;
   logic [CW:0]  demand;

   fp_wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fp_wb_entry_t)
   ) resultQueue (
      .clk      (clk),
      .rst      (rst),
      .push     (pushOk),
      .pushData (newEntry),
      .pop      (popOk),
      .headData (headEntry),
      .count    (fifoCount),
      .empty    (fifoEmpty),
      .full     (fifoFull)
   );

   // Route the head to exactly one register file based on its kind. With an
   // empty queue (including during reset, since count clears asynchronously)
   // both requests and their payloads are held at zero.
   always_comb begin
      vrf_wr_valid = 1'b0;
      vrf_wr_rd    = '0;
      vrf_wr_data  = '0;
      srf_wr_valid = 1'b0;
      srf_wr_rd    = '0;
      srf_wr_data  = '0;
      if (!fifoEmpty) begin
         if (headEntry.kind == SCALAR) begin
            srf_wr_valid = 1'b1;
            srf_wr_rd    = headEntry.rd;
            srf_wr_data  = headEntry.data32;
         end else begin
            vrf_wr_valid = 1'b1;
            vrf_wr_rd    = headEntry.rd;
            vrf_wr_data  = headEntry.data16;
         end
      end
   end

   // Accept a result whenever there is room, or when the head leaves in the
   // same cycle so a full queue can still stream. Error flags only count for
   // results that actually enter the queue; a result that finds no room is
   // recorded as a drop instead.
   always_comb begin
      newEntry.kind   = in_scalar_valid ? SCALAR : VECTOR;
      newEntry.rd     = in_rd;
      newEntry.data16 = in_data;
      newEntry.data32 = in_scalar_data;
      popOk  = (vrf_wr_valid && vrf_wr_ready) || (srf_wr_valid && srf_wr_ready);
      pushOk = in_valid && (!fifoFull || popOk);
      flagSet             = '0;
      flagSet[FFLAG_OF]   = pushOk && in_err_overflow;
      flagSet[FFLAG_NV]   = pushOk && in_err_invalid;
      flagSet[FFLAG_DROP] = in_valid && !pushOk;
   end

   // The ALU has one result in flight, so issuing is only safe while the
   // queue plus that pending result still leaves one free slot.
   always_comb begin
      demand      = {1'b0, fifoCount} + {{CW{1'b0}}, in_valid};
      issue_ready = !rst && (demand <= ISSUE_LIMIT);
      count       = fifoCount;
   end

   // Sticky flags: a clear pulse zeroes them, but any flag being set in the
   // same cycle survives the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fflags <= '0;
      end else begin
         fflags <= (flags_clr ? 3'b000 : fflags) | flagSet;
      end
   end

endmodule

// File: tb/tb_fp_wb_buffer.sv
// Self-checking bench for fp_wb_buffer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a queue model.
module tb_fp_wb_buffer;
   import fp_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [4:0]    in_rd;
   logic [15:0]   in_data;
   logic          in_scalar_valid;
   logic [31:0]   in_scalar_data;
   logic          in_err_overflow;
   logic          in_err_invalid;
   logic          issue_ready;
   logic          vrf_wr_valid;
   logic [4:0]    vrf_wr_rd;
   logic [15:0]   vrf_wr_data;
   logic          vrf_wr_ready;
   logic          srf_wr_valid;
   logic [4:0]    srf_wr_rd;
   logic [31:0]   srf_wr_data;
   logic          srf_wr_ready;
   logic          flags_clr;
   logic [2:0]    fflags;
   logic [CW-1:0] count;

   int            checkCount = 0;
   int            passCount  = 0;
   fp_wb_entry_t  modelQ[$];
   logic [2:0]    modelFlags = 3'b000;
   logic          lastIssueReady;
   logic          aluPending;
   int            pushSeq;
   int            maxCount;

   always #5 clk = ~clk;

   fp_wb_buffer #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_rd           (in_rd),
      .in_data         (in_data),
      .in_scalar_valid (in_scalar_valid),
      .in_scalar_data  (in_scalar_data),
      .in_err_overflow (in_err_overflow),
      .in_err_invalid  (in_err_invalid),
      .issue_ready     (issue_ready),
      .vrf_wr_valid    (vrf_wr_valid),
      .vrf_wr_rd       (vrf_wr_rd),
      .vrf_wr_data     (vrf_wr_data),
      .vrf_wr_ready    (vrf_wr_ready),
      .srf_wr_valid    (srf_wr_valid),
      .srf_wr_rd       (srf_wr_rd),
      .srf_wr_data     (srf_wr_data),
      .srf_wr_ready    (srf_wr_ready),
      .flags_clr       (flags_clr),
      .fflags          (fflags),
      .count           (count)
   );

   // Single comparison point: every check goes through here so the pass and
   // total counters stay consistent with what the summary reports.
   task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [15:0] data,
                                input logic sv, input logic [31:0] sdata, input logic of,
                                input logic nv, input logic vrdy, input logic srdy, input logic clr);
      in_valid        = v;
      in_rd           = rd;
      in_data         = data;
      in_scalar_valid = sv;
      in_scalar_data  = sdata;
      in_err_overflow = of;
      in_err_invalid  = nv;
      vrf_wr_ready    = vrdy;
      srf_wr_ready    = srdy;
      flags_clr       = clr;
   endtask

   // Expected outputs straight from the queue contents: the oldest result goes
   // to its own register file, and issuing is allowed while the queue plus the
   // incoming result stays below DEPTH.
   task automatic checkOutput();
      logic        eVv, eSv, eIr;
      logic [4:0]  eVrd, eSrd;
      logic [15:0] eVd;
      logic [31:0] eSd;
      eVv = 1'b0; eSv = 1'b0; eVrd = '0; eSrd = '0; eVd = '0; eSd = '0;
      if (!rst && modelQ.size() > 0) begin
         if (modelQ[0].kind == SCALAR) begin
            eSv = 1'b1; eSrd = modelQ[0].rd; eSd = modelQ[0].data32;
         end else begin
            eVv = 1'b1; eVrd = modelQ[0].rd; eVd = modelQ[0].data16;
         end
      end
      eIr = !rst && ((modelQ.size() + int'(in_valid)) <= DEPTH - 1);
      compare("vrf_wr_valid", 32'(vrf_wr_valid), 32'(eVv));
      compare("vrf_wr_rd",    32'(vrf_wr_rd),    32'(eVrd));
      compare("vrf_wr_data",  32'(vrf_wr_data),  32'(eVd));
      compare("srf_wr_valid", 32'(srf_wr_valid), 32'(eSv));
      compare("srf_wr_rd",    32'(srf_wr_rd),    32'(eSrd));
      compare("srf_wr_data",  srf_wr_data,       eSd);
      compare("issue_ready",  32'(issue_ready),  32'(eIr));
      compare("count",        32'(count),        32'(modelQ.size()));
      compare("fflags",       32'(fflags),       32'(modelFlags));
   endtask

   task automatic updateModel();
      logic         popM, pushM;
      logic [2:0]   setB;
      fp_wb_entry_t e;
      if (rst) begin
         modelQ.delete();
         modelFlags = 3'b000;
         return;
      end
      popM  = (modelQ.size() > 0) &&
              ((modelQ[0].kind == SCALAR) ? srf_wr_ready : vrf_wr_ready);
      pushM = in_valid && ((modelQ.size() < DEPTH) || popM);
      setB  = 3'b000;
      if (pushM) begin
         setB[FFLAG_OF] = in_err_overflow;
         setB[FFLAG_NV] = in_err_invalid;
      end
      if (in_valid && !pushM) setB[FFLAG_DROP] = 1'b1;
      modelFlags = (flags_clr ? 3'b000 : modelFlags) | setB;
      if (popM) void'(modelQ.pop_front());
      if (pushM) begin
         e.kind   = in_scalar_valid ? SCALAR : VECTOR;
         e.rd     = in_rd;
         e.data16 = in_data;
         e.data32 = in_scalar_data;
         modelQ.push_back(e);
      end
   endtask

   // One clock: check at the falling edge, then advance the model with the
   // inputs that were present at the rising edge.
   task automatic stepCycle();
      @(negedge clk);
      checkOutput();
      lastIssueReady = issue_ready;
      if (int'(count) > maxCount) maxCount = int'(count);
      @(posedge clk);
      #1;
      updateModel();
   endtask

   task automatic idle(input logic vrdy, input logic srdy);
      applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b0, vrdy, srdy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      idle(1'b0, 1'b0);
      aluPending = 1'b0;
      maxCount   = 0;
      #3;
      compare("rst_vrf_valid",   32'(vrf_wr_valid), 32'd0);
      compare("rst_srf_valid",   32'(srf_wr_valid), 32'd0);
      compare("rst_count",       32'(count),        32'd0);
      compare("rst_fflags",      32'(fflags),       32'd0);
      compare("rst_issue_ready", 32'(issue_ready),  32'd0);
      @(posedge clk); #1;
      stepCycle();
      rst = 1'b0;

      // Single vector result, drained immediately.
      applyStimulus(1'b1, 5'd3, 16'h3C00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      stepCycle();
      idle(1'b1, 1'b1);
      #2;
      compare("vec_valid", 32'(vrf_wr_valid), 32'd1);
      compare("vec_rd",    32'(vrf_wr_rd),    32'd3);
      compare("vec_data",  32'(vrf_wr_data),  32'h3C00);
      compare("vec_count", 32'(count),        32'd1);
      stepCycle();
      #2;
      compare("vec_count_after", 32'(count), 32'd0);
      stepCycle();

      // Scalar result must appear only on the scalar port, held while stalled.
      applyStimulus(1'b1, 5'd7, 16'h1234, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      stepCycle();
      idle(1'b1, 1'b0);
      #2;
      compare("sc_srf_valid", 32'(srf_wr_valid), 32'd1);
      compare("sc_srf_rd",    32'(srf_wr_rd),    32'd7);
      compare("sc_srf_data",  srf_wr_data,       32'hFFFF_FFFE);
      compare("sc_vrf_valid", 32'(vrf_wr_valid), 32'd0);
      stepCycle();
      idle(1'b1, 1'b1);
      stepCycle();
      idle(1'b1, 1'b1);
      stepCycle();

      // Issue only when allowed with the vector RF stalled: fills, never drops.
      pushSeq  = 0;
      maxCount = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(aluPending, 5'(pushSeq), 16'h2000 + 16'(pushSeq), 1'b0, 32'h0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (aluPending) pushSeq++;
         stepCycle();
         aluPending = lastIssueReady;
      end
      compare("fill_count",     32'(count),       32'd4);
      compare("fill_max",       32'(maxCount),    32'd4);
      compare("fill_no_drop",   32'(fflags),      32'd0);
      compare("fill_ir_low",    32'(issue_ready), 32'd0);
      aluPending = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idle(1'b1, 1'b0);
         #2;
         compare("fill_drain_data", 32'(vrf_wr_data), 32'h2000 + 32'(k));
         stepCycle();
      end
      compare("fill_drained", 32'(count), 32'd0);

      // Five pushes into a stalled queue: the fifth is dropped.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 5'(i), 16'h5000 + 16'(i), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         stepCycle();
      end
      idle(1'b0, 1'b0);
      #2;
      compare("drop_fflags", 32'(fflags), 32'b100);
      compare("drop_count",  32'(count),  32'd4);
      stepCycle();
      for (int k = 0; k < 4; k++) begin
         idle(1'b1, 1'b0);
         #2;
         compare("drop_drain_rd",   32'(vrf_wr_rd),   32'(k));
         compare("drop_drain_data", 32'(vrf_wr_data), 32'h5000 + 32'(k));
         stepCycle();
      end

      // Set in the same cycle as clear wins; clear alone empties the flags.
      applyStimulus(1'b1, 5'd9, 16'h4400, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      stepCycle();
      idle(1'b1, 1'b0);
      #2;
      compare("clr_set_wins", 32'(fflags), 32'b010);
      flags_clr = 1'b1;
      stepCycle();
      idle(1'b1, 1'b0);
      #2;
      compare("clr_alone", 32'(fflags), 32'd0);
      stepCycle();

      // Asynchronous reset with three results waiting.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'(10 + i), 16'h6000 + 16'(i), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         stepCycle();
      end
      idle(1'b0, 1'b0);
      #2;
      compare("pre_rst_count", 32'(count), 32'd3);
      rst = 1'b1;
      #1;
      compare("arst_vrf_valid", 32'(vrf_wr_valid), 32'd0);
      compare("arst_srf_valid", 32'(srf_wr_valid), 32'd0);
      compare("arst_count",     32'(count),        32'd0);
      compare("arst_vrf_data",  32'(vrf_wr_data),  32'd0);
      compare("arst_ir",        32'(issue_ready),  32'd0);
      modelQ.delete();
      modelFlags = 3'b000;
      stepCycle();
      rst = 1'b0;
      applyStimulus(1'b1, 5'd21, 16'h7777, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      stepCycle();
      idle(1'b1, 1'b1);
      #2;
      compare("post_rst_rd",    32'(vrf_wr_rd),   32'd21);
      compare("post_rst_data",  32'(vrf_wr_data), 32'h7777);
      compare("post_rst_count", 32'(count),       32'd1);
      stepCycle();
      idle(1'b1, 1'b1);
      #2;
      compare("post_rst_empty", 32'(count), 32'd0);
      stepCycle();

      // Randomized traffic that honours issue_ready.
      aluPending = 1'b0;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(aluPending, 5'($urandom), 16'($urandom), 1'($urandom), $urandom,
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 15) == 0));
         stepCycle();
         aluPending = lastIssueReady && ($urandom_range(0, 3) != 0);
      end

      // Randomized traffic that ignores issue_ready, forcing drops and streaming
      // through a full queue.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 9) < 7), 5'($urandom), 16'($urandom), 1'($urandom),
                       $urandom, 1'($urandom), 1'($urandom),
                       1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 7) == 0));
         stepCycle();
      end

      for (int i = 0; i < 20 && modelQ.size() > 0; i++) begin
         idle(1'b1, 1'b1);
         stepCycle();
      end
      idle(1'b1, 1'b1);
      #2;
      compare("final_empty", 32'(count), 32'd0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
